// File: rtl/sub_w_borrow_seq_if.sv
// Handshake and operand/result bundle for the sequential subtractor.
// master drives the request side; slave is the subtractor.
interface sub_w_borrow_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             b_in;
  logic [WIDTH-1:0] in_1;
  logic [WIDTH-1:0] in_2;
  logic [WIDTH-1:0] out;
  logic             b_out;
  logic             ovf;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (
    output start, b_in, in_1, in_2,
    input  out, b_out, ovf, zero, busy, done
  );

  modport slave (
    input  start, b_in, in_1, in_2,
    output out, b_out, ovf, zero, busy, done
  );
endinterface

// File: rtl/sub_w_borrow_seq.sv
// Multi-cycle subtractor with borrow: one CHUNK-bit slice per clock, LSB first.
//
// state | meaning
// IDLE  | waiting for start; last result held on outputs
// RUN   | one slice per clock, slice index in cnt_q
module sub_w_borrow_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic               clk,
  input  logic               rst,
  sub_w_borrow_seq_if.slave  bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             b_out_q, b_out_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK:0]   slice_diff;
  logic [WIDTH-1:0] res_next;

  // Select the active slice, subtract it with the stored borrow, merge into the working result
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        a_slice = a_q[i*CHUNK +: CHUNK];
        b_slice = b_q[i*CHUNK +: CHUNK];
      end
    end
    slice_diff = {1'b0, a_slice} - {1'b0, b_slice} - {{CHUNK{1'b0}}, borrow_q};
    res_next = res_q;
    for (int i = 0; i < N; i++) begin
      if (cnt_q == CW'(i)) begin
        res_next[i*CHUNK +: CHUNK] = slice_diff[CHUNK-1:0];
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    res_d    = res_q;
    out_d    = out_q;
    b_out_d  = b_out_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.in_1;
          b_d      = bus.in_2;
          borrow_d = bus.b_in;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        res_d    = res_next;
        borrow_d = slice_diff[CHUNK];
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          out_d   = res_next;
          b_out_d = slice_diff[CHUNK];
          // signed overflow: operand signs differ and the result sign departs from the minuend
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_next[WIDTH-1] != a_q[WIDTH-1]);
          zero_d  = (res_next == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      res_q    <= '0;
      out_q    <= '0;
      b_out_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      res_q    <= res_d;
      out_q    <= out_d;
      b_out_q  <= b_out_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.out   = out_q;
  assign bus.b_out = b_out_q;
  assign bus.ovf   = ovf_q;
  assign bus.zero  = zero_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_sub_w_borrow_seq.sv
// Scoreboard bench for sub_w_borrow_seq (WIDTH=32, CHUNK=8).
module tb_sub_w_borrow_seq;
  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;

  typedef struct packed {
    logic [WIDTH-1:0] out;
    logic             b_out;
    logic             ovf;
    logic             zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  logic done_prev = 1'b0;

  sub_w_borrow_seq_if #(.WIDTH(WIDTH)) bus ();

  sub_w_borrow_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi);
    exp_t e;
    logic [WIDTH:0] d;
    d = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};
    e.out   = d[WIDTH-1:0];
    e.b_out = d[WIDTH];
    e.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
    e.zero  = (d[WIDTH-1:0] == '0);
    return e;
  endfunction

  // Scoreboard: every done pulse pops one expected result
  always @(negedge clk) begin
    if (bus.done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("out",   64'(bus.out),   64'(e.out));
        chk("b_out", 64'(bus.b_out), 64'(e.b_out));
        chk("ovf",   64'(bus.ovf),   64'(e.ovf));
        chk("zero",  64'(bus.zero),  64'(e.zero));
      end
      if (done_prev) chk("done_width", 64'd2, 64'd1);
    end
    done_prev = bus.done;
  end

  // Drive one start pulse sampled at the next edge; optionally push the expectation
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi, input bit push);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.in_1  = a;
    bus.in_2  = b;
    bus.b_in  = bi;
    if (push) sb_q.push_back(model(a, b, bi));
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.in_1  = $urandom;
    bus.in_2  = $urandom;
    bus.b_in  = 1'($urandom);
  endtask

  // Wait for done; with check_lat set, also check latency and busy length from the start edge
  task automatic wait_done(input bit check_lat);
    int busy_cnt;
    bit seen;
    busy_cnt = 0;
    seen = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.done) begin
        if (check_lat) begin
          chk("latency",  64'(k),        64'(N + 1));
          chk("busy_len", 64'(busy_cnt), 64'(N));
          chk("busy_at_done", 64'(bus.busy), 64'd0);
        end
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_cnt++;
    end
    if (!seen) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit stray;
    bus.start = 1'b0;
    bus.b_in  = 1'b0;
    bus.in_1  = '0;
    bus.in_2  = '0;
    #12;
    chk("rst_out",  64'(bus.out),  64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_flags", 64'({bus.b_out, bus.ovf, bus.zero}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases
    start_op(32'h00000005, 32'h00000003, 1'b0, 1'b1);
    chk("busy_after_start", 64'(bus.busy), 64'd1);
    chk("hold_out", 64'(bus.out), 64'd0);
    wait_done(1'b1);
    start_op(32'h00000000, 32'h00000001, 1'b0, 1'b1);
    wait_done(1'b1);
    start_op(32'h80000000, 32'h00000001, 1'b0, 1'b1);
    wait_done(1'b1);
    start_op(32'h12345678, 32'h12345677, 1'b1, 1'b1);
    wait_done(1'b1);

    // Start while busy is ignored
    start_op(32'h00000010, 32'h00000001, 1'b0, 1'b1);
    start_op(32'h000000FF, 32'h000000FF, 1'b0, 1'b0);
    chk("busy_ignore", 64'(bus.busy), 64'd1);
    wait_done(1'b0);
    chk("ignored_result", 64'(bus.out), 64'h0000000F);

    // Start held during the done cycle is accepted
    start_op(32'h00000007, 32'h00000002, 1'b0, 1'b1);
    wait_done(1'b0);
    bus.start = 1'b1;
    bus.in_1  = 32'h00000020;
    bus.in_2  = 32'h00000030;
    bus.b_in  = 1'b0;
    sb_q.push_back(model(32'h00000020, 32'h00000030, 1'b0));
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b_busy", 64'(bus.busy), 64'd1);
    chk("b2b_done_drop", 64'(bus.done), 64'd0);
    chk("b2b_hold_out", 64'(bus.out), 64'h00000005);
    wait_done(1'b0);
    chk("b2b_result", 64'(bus.out), 64'hFFFFFFF0);

    // Reset mid-run
    start_op(32'h00000100, 32'h00000001, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_done", 64'(bus.done), 64'd0);
    chk("midrst_out",  64'(bus.out),  64'd0);
    chk("midrst_flags", 64'({bus.b_out, bus.ovf, bus.zero}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    stray = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) stray = 1'b1;
    end
    chk("no_done_after_rst", 64'(stray), 64'd0);
    start_op(32'h00000100, 32'h00000001, 1'b0, 1'b1);
    wait_done(1'b1);
    chk("fresh_result", 64'(bus.out), 64'h000000FF);

    // Random operands
    for (int i = 0; i < 8; i++) begin
      start_op($urandom, $urandom, 1'($urandom), 1'b1);
      wait_done(1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sub_w_borrow_seq.md
Name: sub_w_borrow_seq

Overview:
- Multi-cycle subtractor with borrow-in/borrow-out. It is the subtract-direction companion to the team's ripple adder with carry.
- Processes a WIDTH-bit operand pair one CHUNK-bit slice per clock, LSB slice first, so a narrow ripple chain is reused over several cycles.
- Start/busy/done handshake. Feeds multi-precision arithmetic and compare paths where area matters more than latency.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 8, bits processed per clock; 1 <= CHUNK <= WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while idle.
- b_in  input  1  borrow-in; latched with start.
- in_1  input  WIDTH  minuend; latched with start.
- in_2  input  WIDTH  subtrahend; latched with start.
- out  output  WIDTH  difference (in_1 - in_2 - b_in) mod 2^WIDTH.
- b_out  output  1  final borrow; 1 iff in_1 < in_2 + b_in (unsigned).
- ovf  output  1  signed overflow of the subtraction.
- zero  output  1  out == 0.
- busy  output  1  operation in progress.
- done  output  1  one-cycle result-valid pulse.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is asynchronous and active-high.
- Reset: all outputs 0. Internal slice counter, operand registers and borrow register 0. State IDLE.
- States: IDLE and RUN. N = WIDTH/CHUNK.
- IDLE, start=1 at edge E0:
  - latch in_1, in_2, b_in into internal registers;
  - busy=1; done=0; slice counter=0;
  - go to RUN.
  - out, b_out, ovf and zero keep their previous values until completion.
- RUN, edges E1..EN: at edge Ek, slice k-1 computes diff = a_slice - b_slice - borrow (CHUNK+1-bit arithmetic).
  - Low CHUNK bits are written to the result register at that slice position.
  - The borrow register takes the slice borrow.
  - The counter increments.
- At edge EN:
  - state goes to IDLE; busy=0; done=1 for exactly one cycle;
  - out = full result; b_out = final borrow;
  - ovf = (a[W-1] != b[W-1]) && (out[W-1] != a[W-1]), using the latched operands;
  - zero = (out == 0).
- Latency: done is high in the cycle following EN, i.e. N clocks after the start-sampling edge. Throughput: one operation per N+1 cycles minimum.
- start while busy=1: ignored. Latched operands are not disturbed.
- start while done=1: the block is already IDLE, so start is accepted. done drops after the next edge, busy rises, and outputs hold the previous result until the new completion.
- in_1/in_2/b_in may change freely after E0. Only the latched copies are used.
- Results persist in IDLE until the next completion or reset.
- rst asserted mid-RUN: immediate return to IDLE; all outputs 0; no done pulse. An operation is started again only by a new start after rst is released.
- CHUNK == WIDTH: N=1; done is high one cycle after start.
- Borrow propagates across slice boundaries through the borrow register only. No combinational path exists from inputs to outputs.

Test Plan (WIDTH=32, CHUNK=8, N=4):
- in_1=0x00000005, in_2=0x00000003, b_in=0, start pulse -> busy high 4 cycles; done high 1 cycle, 4 clocks after start edge; out=0x00000002, b_out=0, ovf=0, zero=0.
- in_1=0x00000000, in_2=0x00000001, b_in=0 -> out=0xFFFFFFFF, b_out=1, ovf=0. Borrow crosses all four slices.
- in_1=0x80000000, in_2=0x00000001, b_in=0 -> out=0x7FFFFFFF, b_out=0, ovf=1.
- in_1=0x12345678, in_2=0x12345677, b_in=1 -> out=0x00000000, zero=1, b_out=0, ovf=0.
- Handshake:
  - start with 0x10-0x01; then pulse start again at cycle 2 with 0xFF-0xFF -> second start ignored; result 0x0000000F.
  - start held high during the done cycle with 0x20-0x30 -> accepted; next done gives out=0xFFFFFFF0, b_out=1.
- Mid-run reset: start with 0x100-0x1, assert rst after 2 cycles -> busy, done, out, b_out, ovf and zero all 0 immediately. No done after release. A fresh start completes normally with out=0x000000FF.
